adc128s_fc: RTL and testbench

//  Behavioural bench model of the 8-channel, 12-bit SPI A2D converter on the Segway A2D bus.
//  - Acts as an SPI slave to the DUT's A2D interface.
//  - Decodes the channel address carried in each 16-bit frame.
//  - Returns, on the following frame, the 12-bit value presented on the matching analog input.
//  - Sits in the testbench between the DUT A2D pins and the stimulus regs: load cells, steer pot, battery.

---
 rtl/adc128s_pkg.sv | 12 +
 rtl/adc128s_fc_if.sv | 31 +++
 rtl/adc128s_sync_edge.sv | 33 +++
 rtl/adc128s_fc.sv | 128 ++++++++++++
 tb/tb_adc128s_fc.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/adc128s_pkg.sv
// Package for the adc128s_fc A2D converter bench model.
// Holds the channel addresses that map onto real analog inputs and the SPI frame length.
package adc128s_pkg;

    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT  = 3'd6;

    localparam int unsigned FRAME_BITS = 16;

endpackage

// File: rtl/adc128s_fc_if.sv
// SPI bus between the A2D master and the adc128s_fc slave model.
//   SS_n    : slave select, active low (master -> slave)
//   SCLK    : serial clock, idles high (master -> slave)
//   MOSI    : master-out data (master -> slave)
//   MISO    : slave-out data (slave -> master)
//   MISO_oe : MISO pad enable; low means the pad is high-Z
interface adc128s_fc_if;

    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
    logic MISO_oe;

    modport master (
        output SS_n,
        output SCLK,
        output MOSI,
        input  MISO,
        input  MISO_oe
    );

    modport slave (
        input  SS_n,
        input  SCLK,
        input  MOSI,
        output MISO,
        output MISO_oe
    );

endinterface

// File: rtl/adc128s_sync_edge.sv
// Two-flop synchronizer plus one history flop, with single-clk rise/fall pulses.
//   clk, rst_n : clock and asynchronous active-low reset
//   async_i    : asynchronous input
//   sync_o     : synchronized level
//   rise_o     : one-clk pulse on synchronized 0->1
//   fall_o     : one-clk pulse on synchronized 1->0
module adc128s_sync_edge #(
    parameter logic RstVal = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RstVal}};
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    // sync_q[1] is the synchronized level, sync_q[2] its one-clk history.
    assign sync_o = sync_q[1];
    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/adc128s_fc.sv
// Behavioural model of an 8-channel 12-bit SPI A2D converter acting as SPI slave.
// Each 16-bit frame carries a channel address in MOSI[13:11]; the frame that follows
// returns {4'b0000, value} of that channel on MISO, MSB first.
//   clk, rst_n       : clock and asynchronous active-low reset
//   spi              : SPI slave modport (SS_n, SCLK, MOSI in; MISO, MISO_oe out)
//   ld_cell_lft_i    : channel 0 value
//   ld_cell_rght_i   : channel 4 value
//   steer_pot_i      : channel 5 value
//   batt_i           : channel 6 value
module adc128s_fc
    import adc128s_pkg::*;
#(
    parameter logic [11:0] UNUSED_VAL = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    adc128s_fc_if.slave spi,
    input  logic [11:0] ld_cell_lft_i,
    input  logic [11:0] ld_cell_rght_i,
    input  logic [11:0] steer_pot_i,
    input  logic [11:0] batt_i
);

    localparam logic [4:0] FullCnt = 5'(FRAME_BITS);

    logic ss_sync, ss_rise, ss_fall;
    logic sclk_sync_unused, sclk_rise, sclk_fall;
    logic [1:0] mosi_q;
    logic mosi_sync;

    logic [2:0]  addr_q, addr_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] tx_q, tx_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        seen_q, seen_d;
    logic [11:0] ch_val;
    logic        rx_msb_unused;

    adc128s_sync_edge #(.RstVal(1'b1)) u_ss_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(spi.SS_n),
        .sync_o (ss_sync),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    adc128s_sync_edge #(.RstVal(1'b1)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(spi.SCLK),
        .sync_o (sclk_sync_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // Two flops so MOSI lines up with the synchronized SCLK level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_q <= 2'b00;
        end else begin
            mosi_q <= {mosi_q[0], spi.MOSI};
        end
    end
    assign mosi_sync = mosi_q[1];

    always_comb begin
        case (addr_q)
            CH_LFT:   ch_val = ld_cell_lft_i;
            CH_RGHT:  ch_val = ld_cell_rght_i;
            CH_STEER: ch_val = steer_pot_i;
            CH_BATT:  ch_val = batt_i;
            default:  ch_val = UNUSED_VAL;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        rx_d   = rx_q;
        tx_d   = tx_q;
        cnt_d  = cnt_q;
        seen_d = seen_q;
        if (ss_fall) begin
            tx_d = {4'b0000, ch_val};
        end
        // Frame end takes priority over any SCLK edge in the same clk.
        if (ss_rise) begin
            if (cnt_q == FullCnt) begin
                addr_d = rx_q[13:11];
            end
            cnt_d  = '0;
            seen_d = 1'b0;
        end else if (!ss_sync) begin
            if (sclk_rise) begin
                rx_d   = {rx_q[14:0], mosi_sync};
                seen_d = 1'b1;
                if (cnt_q != FullCnt) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            // Ignore the leading fall of an idle-high SCLK so bit 15 is held for one bit time.
            if (sclk_fall && seen_q) begin
                tx_d = {tx_q[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= 3'd0;
            rx_q   <= '0;
            tx_q   <= '0;
            cnt_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            rx_q   <= rx_d;
            tx_q   <= tx_d;
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
        end
    end

    assign rx_msb_unused = rx_q[15];
    assign spi.MISO      = tx_q[15];
    assign spi.MISO_oe   = ~ss_sync;

endmodule

// File: tb/tb_adc128s_fc.sv
// Self-checking bench for adc128s_fc: drives SPI frames as the A2D master and checks the
// returned words against a scoreboard built from a small address-pipeline model.
module tb_adc128s_fc;

    logic clk = 1'b0;
    logic rst_n;
    logic [11:0] lft, rght, steer, batt;

    always #5 clk = ~clk;

    adc128s_fc_if spi ();

    adc128s_fc #(.UNUSED_VAL(12'h000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi           (spi),
        .ld_cell_lft_i (lft),
        .ld_cell_rght_i(rght),
        .steer_pot_i   (steer),
        .batt_i        (batt)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic [2:0]  model_addr = 3'd0;
    logic [15:0] got;
    logic [15:0] exp_w;

    function automatic logic [11:0] model_ch(input logic [2:0] a);
        case (a)
            3'd0:    return lft;
            3'd4:    return rght;
            3'd5:    return steer;
            3'd6:    return batt;
            default: return 12'h000;
        endcase
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master-side frame: data changes on SCLK fall, MISO sampled just before SCLK rise.
    task automatic frame(input logic [31:0] data, input int nbits, input bit mid_chg,
                         output logic [15:0] rx_word);
        rx_word = '0;
        spi.SS_n = 1'b0;
        wait_clk(5);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi.SCLK = 1'b0;
            spi.MOSI = data[i];
            if (mid_chg && i == nbits - 3) begin
                lft = ~lft; rght = ~rght; steer = ~steer; batt = ~batt;
            end
            wait_clk(4);
            if (nbits - 1 - i < 16) rx_word = {rx_word[14:0], spi.MISO};
            spi.SCLK = 1'b1;
            wait_clk(4);
        end
        spi.SS_n = 1'b1;
        wait_clk(6);
    endtask

    // Complete frame addressing channel a; pushes the expected reply of this frame.
    task automatic sb_frame(input logic [2:0] a, input bit mid_chg, output logic [15:0] rx_word);
        logic [15:0] w;
        w = (16'($urandom) & 16'hC7FF) | (16'(a) << 11);
        exp_q.push_back({4'b0000, model_ch(model_addr)});
        frame({16'h0000, w}, 16, mid_chg, rx_word);
        model_addr = a;
    endtask

    task automatic test_reset;
        spi.SS_n = 1'b1; spi.SCLK = 1'b1; spi.MOSI = 1'b0;
        lft = 12'h200; rght = 12'h000; steer = 12'h000; batt = 12'h000;
        rst_n = 1'b0;
        wait_clk(3);
        total++;
        if (spi.MISO_oe !== 1'b0) begin
            bad++; $display("FAIL reset_oe: got %b want 0 (Z)", spi.MISO_oe);
        end
        total++;
        if (spi.MISO !== 1'b0) begin
            bad++; $display("FAIL reset_miso: got %b want 0", spi.MISO);
        end
        rst_n = 1'b1;
        model_addr = 3'd0;
        wait_clk(3);
    endtask

    task automatic test_first_frame;
        sb_frame(3'd0, 1'b0, got);
        exp_w = exp_q.pop_front();
        total++;
        if (got !== exp_w || got !== 16'h0200) begin
            bad++; $display("FAIL first_frame: got %h want %h", got, exp_w);
        end
    endtask

    task automatic test_batt;
        sb_frame(3'd6, 1'b0, got);
        exp_w = exp_q.pop_front();
        total++;
        if (got !== exp_w) begin
            bad++; $display("FAIL batt_setup: got %h want %h", got, exp_w);
        end
        batt = 12'h900;
        // Inputs flip mid-frame; the reply must hold the value latched at frame start.
        sb_frame(3'd0, 1'b1, got);
        exp_w = exp_q.pop_front();
        total++;
        if (got !== exp_w || got !== 16'h0900) begin
            bad++; $display("FAIL batt_frame: got %h want %h", got, exp_w);
        end
    endtask

    task automatic test_sequence;
        logic [2:0] seq[5] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd0};
        lft = 12'h200; rght = 12'h200; steer = 12'h123; batt = 12'h900;
        for (int i = 0; i < 5; i++) begin
            sb_frame(seq[i], 1'b0, got);
            exp_w = exp_q.pop_front();
            total++;
            if (got !== exp_w) begin
                bad++; $display("FAIL seq_frame%0d: got %h want %h", i, got, exp_w);
            end
        end
    endtask

    task automatic test_unused;
        logic [2:0] seq[4] = '{3'd3, 3'd7, 3'd1, 3'd2};
        for (int i = 0; i < 4; i++) begin
            sb_frame(seq[i], 1'b0, got);
            exp_w = exp_q.pop_front();
            total++;
            if (got !== exp_w) begin
                bad++; $display("FAIL unused_frame%0d: got %h want %h", i, got, exp_w);
            end
        end
    endtask

    task automatic test_abort;
        rght = 12'h4a5;
        sb_frame(3'd4, 1'b0, got);
        exp_w = exp_q.pop_front();
        total++;
        if (got !== exp_w) begin
            bad++; $display("FAIL abort_setup: got %h want %h", got, exp_w);
        end
        // 8 rises carrying addr 5, then SS_n rises: address must stay 4.
        frame(32'h0000_0028, 8, 1'b0, got);
        // SCLK activity while deselected must be ignored.
        for (int i = 0; i < 4; i++) begin
            spi.SCLK = 1'b0; wait_clk(4);
            spi.SCLK = 1'b1; wait_clk(4);
        end
        sb_frame(3'd0, 1'b0, got);
        exp_w = exp_q.pop_front();
        total++;
        if (got !== exp_w || got !== 16'h04a5) begin
            bad++; $display("FAIL abort_frame: got %h want %h", got, exp_w);
        end
    endtask

    task automatic test_overrun;
        steer = 12'h5c3;
        // 18 rises: the last 16 bits (addr 5) are what remain in the receive register.
        exp_q.push_back({4'b0000, model_ch(model_addr)});
        frame(32'h0002_E800, 18, 1'b0, got);
        model_addr = 3'd5;
        exp_w = exp_q.pop_front();
        total++;
        if (got !== exp_w) begin
            bad++; $display("FAIL overrun_frame: got %h want %h", got, exp_w);
        end
        sb_frame(3'd0, 1'b0, got);
        exp_w = exp_q.pop_front();
        total++;
        if (got !== exp_w || got !== 16'h05c3) begin
            bad++; $display("FAIL overrun_next: got %h want %h", got, exp_w);
        end
    endtask

    task automatic test_reset_mid;
        lft = 12'h3e1;
        sb_frame(3'd6, 1'b0, got);
        exp_w = exp_q.pop_front();
        total++;
        if (got !== exp_w) begin
            bad++; $display("FAIL rstmid_setup: got %h want %h", got, exp_w);
        end
        spi.SS_n = 1'b0;
        wait_clk(5);
        total++;
        if (spi.MISO_oe !== 1'b1) begin
            bad++; $display("FAIL rstmid_oe_active: got %b want 1", spi.MISO_oe);
        end
        for (int i = 0; i < 5; i++) begin
            spi.SCLK = 1'b0; spi.MOSI = 1'b1; wait_clk(4);
            spi.SCLK = 1'b1; wait_clk(4);
        end
        rst_n = 1'b0;
        wait_clk(2);
        total++;
        if (spi.MISO_oe !== 1'b0) begin
            bad++; $display("FAIL rstmid_oe: got %b want 0 (Z)", spi.MISO_oe);
        end
        rst_n = 1'b1;
        model_addr = 3'd0;
        wait_clk(3);
        spi.SS_n = 1'b1;
        wait_clk(6);
        sb_frame(3'd5, 1'b0, got);
        exp_w = exp_q.pop_front();
        total++;
        if (got !== exp_w || got !== 16'h03e1) begin
            bad++; $display("FAIL rstmid_frame: got %h want %h", got, exp_w);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_batt();
        test_sequence();
        test_unused();
        test_abort();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
